// File: rtl/fmul_round_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fmul_round_stage_pkg
//  Purpose  : Shared FP32 field widths, special-value constants and types for
//             the FMUL rounding stage and its rounding sub-module.
//  Ports    : (package - no ports)
//  Revision : 1.0 - initial release
// ============================================================================
package fmul_round_stage_pkg;

   localparam int EXP_W  = 8;
   localparam int FRAC_W = 23;
   localparam int FP_W   = 1 + EXP_W + FRAC_W;

   localparam logic [EXP_W-1:0] EXP_MAX      = 8'hFF;
   localparam logic [FP_W-1:0]  QNAN_DEFAULT = 32'h7FC00000;
   localparam logic [FP_W-1:0]  INF_POS      = 32'h7F800000;

   typedef struct packed {
      logic              sign;
      logic [EXP_W-1:0]  exp;
      logic [FRAC_W-1:0] frac;
   } fp32_t;

   // Signed infinity: sign bit followed by the positive-infinity pattern.
   function automatic fp32_t make_inf(input logic sign);
      fp32_t r;
      r      = fp32_t'(INF_POS);
      r.sign = sign;
      return r;
   endfunction

endpackage : fmul_round_stage_pkg
`default_nettype wire

// File: rtl/fmul_round_stage_rne.sv
`default_nettype none
// ============================================================================
//  Module   : fp32_round_rne
//  Purpose  : Combinational FP32 rounding. Applies round-to-nearest-even (or
//             truncation), propagates a fraction carry into the exponent and
//             saturates to infinity on exponent overflow.
//  Ports    : sign/exp/frac  - unrounded result fields
//             rd, sticky     - guard bit and OR of remaining discarded bits
//             mode           - 1 = round-to-nearest-even, 0 = truncate
//             y              - packed {sign, exp, frac} result
//             overflow       - result is infinity (input exp saturated or
//                              rounding carried into EXP_MAX)
//             inexact        - discarded bits were nonzero
//  Revision : 1.0 - initial release
// ============================================================================
module fp32_round_rne
   import fmul_round_stage_pkg::*;
(
   input  logic              sign,
   input  logic [EXP_W-1:0]  exp,
   input  logic [FRAC_W-1:0] frac,
   input  logic              rd,
   input  logic              sticky,
   input  logic              mode,
   output logic [FP_W-1:0]   y,
   output logic              overflow,
   output logic              inexact
);

   logic              inc;
   logic [FRAC_W:0]   sum;
   logic              carry;
   logic [EXP_W-1:0]  exp_inc;

   always_comb begin
      // Round up above half, or on an exact tie when the LSB is odd.
      inc      = mode & rd & (sticky | frac[0]);
      sum      = {1'b0, frac} + {{FRAC_W{1'b0}}, inc};
      carry    = sum[FRAC_W];
      exp_inc  = exp + EXP_W'(1);

      y        = {sign, exp, sum[FRAC_W-1:0]};
      overflow = 1'b0;
      inexact  = rd | sticky;

      if (exp == EXP_MAX) begin
         // Already saturated: emit infinity without rounding.
         y        = make_inf(sign);
         overflow = 1'b1;
         inexact  = 1'b0;
      end else if (carry) begin
         // Fraction wrapped to zero; mantissa 1.111.. became 10.000..
         if (exp_inc == EXP_MAX) begin
            y        = make_inf(sign);
            overflow = 1'b1;
            inexact  = 1'b1;
         end else begin
            y = {sign, exp_inc, {FRAC_W{1'b0}}};
         end
      end
   end

endmodule : fp32_round_rne
`default_nettype wire

// File: rtl/fmul_round_stage.sv
`default_nettype none
// ============================================================================
//  Module   : fmul_round_stage
//  Purpose  : Two-register rounding pipeline behind the FMUL datapath.
//             S1 captures raw fields, rounding runs between S1 and S2, and S2
//             drives the packed result and per-result status. Valid/ready
//             backpressure on both sides; sticky status flags for software.
//  Ports    : clk, rst                      - clock, async active-high reset
//             in_valid/in_ready             - upstream handshake
//             in_sign/exp/frac/rd/sticky    - unrounded result fields
//             in_error, in_overflow         - FMUL status for this result
//             out_valid/out_ready           - downstream handshake
//             out_y                         - packed FP32 result
//             out_error/overflow/inexact    - status of out_y
//             flag_clr                      - clears sticky flags
//             flag_overflow/error/inexact   - sticky OR over delivered results
//  Revision : 1.0 - initial release
// ============================================================================
module fmul_round_stage
   import fmul_round_stage_pkg::*;
#(
   parameter int              ROUND_MODE = 1,
   parameter logic [FP_W-1:0] QNAN       = QNAN_DEFAULT
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_sign,
   input  logic [EXP_W-1:0]  in_exp,
   input  logic [FRAC_W-1:0] in_frac,
   input  logic              in_rd,
   input  logic              in_sticky,
   input  logic              in_error,
   input  logic              in_overflow,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [FP_W-1:0]   out_y,
   output logic              out_error,
   output logic              out_overflow,
   output logic              out_inexact,
   input  logic              flag_clr,
   output logic              flag_overflow,
   output logic              flag_error,
   output logic              flag_inexact
);

   localparam logic MODE_RNE = (ROUND_MODE != 0);

   // S1 registers (raw inputs)
   logic              s1_valid;
   logic              s1_sign;
   logic [EXP_W-1:0]  s1_exp;
   logic [FRAC_W-1:0] s1_frac;
   logic              s1_rd;
   logic              s1_sticky;
   logic              s1_error;
   logic              s1_overflow;

   // Handshake
   logic s2_free;
   logic s1_free;
   logic out_xfer;

   assign s2_free  = !out_valid || out_ready;
   assign s1_free  = !s1_valid || s2_free;
   assign in_ready = s1_free;
   assign out_xfer = out_valid && out_ready;

   // Rounding between S1 and S2
   logic [FP_W-1:0] rnd_y;
   logic            rnd_overflow;
   logic            rnd_inexact;

   fp32_round_rne u_round (
      .sign     (s1_sign),
      .exp      (s1_exp),
      .frac     (s1_frac),
      .rd       (s1_rd),
      .sticky   (s1_sticky),
      .mode     (MODE_RNE),
      .y        (rnd_y),
      .overflow (rnd_overflow),
      .inexact  (rnd_inexact)
   );

   logic [FP_W-1:0] nxt_y;
   logic            nxt_error;
   logic            nxt_overflow;
   logic            nxt_inexact;

   // Invalid operation dominates; an upstream overflow bypasses rounding.
   always_comb begin
      nxt_y        = rnd_y;
      nxt_error    = 1'b0;
      nxt_overflow = rnd_overflow;
      nxt_inexact  = rnd_inexact;
      if (s1_error) begin
         nxt_y        = QNAN;
         nxt_error    = 1'b1;
         nxt_overflow = 1'b0;
         nxt_inexact  = 1'b0;
      end else if (s1_overflow) begin
         nxt_y        = make_inf(s1_sign);
         nxt_overflow = 1'b1;
         nxt_inexact  = 1'b0;
      end
   end

   // S1: refills whenever it is empty or its content moves on this cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid    <= 1'b0;
         s1_sign     <= 1'b0;
         s1_exp      <= '0;
         s1_frac     <= '0;
         s1_rd       <= 1'b0;
         s1_sticky   <= 1'b0;
         s1_error    <= 1'b0;
         s1_overflow <= 1'b0;
      end else if (s1_free) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_sign     <= in_sign;
            s1_exp      <= in_exp;
            s1_frac     <= in_frac;
            s1_rd       <= in_rd;
            s1_sticky   <= in_sticky;
            s1_error    <= in_error;
            s1_overflow <= in_overflow;
         end
      end
   end

   // S2: output registers hold while stalled so data stays stable.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid    <= 1'b0;
         out_y        <= '0;
         out_error    <= 1'b0;
         out_overflow <= 1'b0;
         out_inexact  <= 1'b0;
      end else if (s2_free) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            out_y        <= nxt_y;
            out_error    <= nxt_error;
            out_overflow <= nxt_overflow;
            out_inexact  <= nxt_inexact;
         end
      end
   end

   // Sticky flags: a delivered result setting a flag wins over a clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flag_overflow <= 1'b0;
         flag_error    <= 1'b0;
         flag_inexact  <= 1'b0;
      end else begin
         flag_overflow <= (flag_overflow && !flag_clr) || (out_xfer && out_overflow);
         flag_error    <= (flag_error    && !flag_clr) || (out_xfer && out_error);
         flag_inexact  <= (flag_inexact  && !flag_clr) || (out_xfer && out_inexact);
      end
   end

endmodule : fmul_round_stage
`default_nettype wire

// File: tb/tb_fmul_round_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fmul_round_stage
//  Purpose  : Self-checking bench for fmul_round_stage (RNE instance plus a
//             truncating instance). Expected results are queued on accept
//             and popped when the DUT delivers a result.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fmul_round_stage;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // RNE instance
   logic        in_valid, in_ready, in_sign, in_rd, in_sticky, in_error, in_overflow;
   logic [7:0]  in_exp;
   logic [22:0] in_frac;
   logic        out_valid, out_ready, out_error, out_overflow, out_inexact;
   logic [31:0] out_y;
   logic        flag_clr, flag_overflow, flag_error, flag_inexact;

   // Truncating instance
   logic        t_in_valid, t_in_ready, t_in_sign, t_in_rd, t_in_sticky, t_in_error, t_in_overflow;
   logic [7:0]  t_in_exp;
   logic [22:0] t_in_frac;
   logic        t_out_valid, t_out_ready, t_out_error, t_out_overflow, t_out_inexact;
   logic [31:0] t_out_y;
   logic        t_flag_clr, t_flag_overflow, t_flag_error, t_flag_inexact;

   fmul_round_stage #(.ROUND_MODE(1)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_sign(in_sign), .in_exp(in_exp),
      .in_frac(in_frac), .in_rd(in_rd), .in_sticky(in_sticky), .in_error(in_error),
      .in_overflow(in_overflow), .out_valid(out_valid), .out_ready(out_ready),
      .out_y(out_y), .out_error(out_error), .out_overflow(out_overflow),
      .out_inexact(out_inexact), .flag_clr(flag_clr), .flag_overflow(flag_overflow),
      .flag_error(flag_error), .flag_inexact(flag_inexact)
   );

   fmul_round_stage #(.ROUND_MODE(0)) dut_trunc (
      .clk(clk), .rst(rst),
      .in_valid(t_in_valid), .in_ready(t_in_ready), .in_sign(t_in_sign), .in_exp(t_in_exp),
      .in_frac(t_in_frac), .in_rd(t_in_rd), .in_sticky(t_in_sticky), .in_error(t_in_error),
      .in_overflow(t_in_overflow), .out_valid(t_out_valid), .out_ready(t_out_ready),
      .out_y(t_out_y), .out_error(t_out_error), .out_overflow(t_out_overflow),
      .out_inexact(t_out_inexact), .flag_clr(t_flag_clr), .flag_overflow(t_flag_overflow),
      .flag_error(t_flag_error), .flag_inexact(t_flag_inexact)
   );

   typedef struct packed {
      logic [31:0] y;
      logic        err;
      logic        ovf;
      logic        inx;
   } res_t;

   typedef struct packed {
      logic        sign;
      logic [7:0]  exp;
      logic [22:0] frac;
      logic        rd;
      logic        st;
      logic        err;
      logic        ovf;
   } vin_t;

   res_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   function automatic vin_t mk(input logic s, input logic [7:0] e, input logic [22:0] f,
                               input logic r, input logic st, input logic er, input logic ov);
      vin_t v;
      v.sign = s; v.exp = e; v.frac = f; v.rd = r; v.st = st; v.err = er; v.ovf = ov;
      return v;
   endfunction

   function automatic res_t mr(input logic [31:0] y, input logic er, input logic ov, input logic ix);
      res_t r;
      r.y = y; r.err = er; r.ovf = ov; r.inx = ix;
      return r;
   endfunction

   task automatic drive(input vin_t v, input logic valid);
      in_valid    = valid;
      in_sign     = v.sign;
      in_exp      = v.exp;
      in_frac     = v.frac;
      in_rd       = v.rd;
      in_sticky   = v.st;
      in_error    = v.err;
      in_overflow = v.ovf;
   endtask

   task automatic t_drive(input vin_t v, input logic valid);
      t_in_valid    = valid;
      t_in_sign     = v.sign;
      t_in_exp      = v.exp;
      t_in_frac     = v.frac;
      t_in_rd       = v.rd;
      t_in_sticky   = v.st;
      t_in_error    = v.err;
      t_in_overflow = v.ovf;
   endtask

   // ------------------------------------------------------------------------
   task automatic test_reset();
      rst = 1'b1;
      drive('0, 1'b0);
      t_drive('0, 1'b0);
      out_ready = 1'b1; t_out_ready = 1'b1;
      flag_clr = 1'b0;  t_flag_clr = 1'b0;
      @(negedge clk);
      checks++;
      if ({out_valid, out_y, out_error, out_overflow, out_inexact} !== 36'h0) begin
         errors++;
         $display("FAIL reset_outputs: got v=%b y=%h e=%b o=%b i=%b, expected all zero",
                  out_valid, out_y, out_error, out_overflow, out_inexact);
      end
      checks++;
      if ({flag_overflow, flag_error, flag_inexact} !== 3'b000) begin
         errors++;
         $display("FAIL reset_flags: got %b, expected 000", {flag_overflow, flag_error, flag_inexact});
      end
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_ready: got %b, expected 1", in_ready);
      end
   endtask

   // Tie with even LSB; also measures accept-to-valid latency.
   task automatic test_latency();
      int   lat;
      res_t got;
      res_t e;
      out_ready = 1'b1;
      @(posedge clk); #1 drive(mk(1'b0, 8'h7F, 23'h0, 1'b1, 1'b0, 1'b0, 1'b0), 1'b1);
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL latency_accept: in_ready got %b, expected 1", in_ready);
      end
      exp_q.push_back(mr(32'h3F800000, 1'b0, 1'b0, 1'b1));
      @(posedge clk); #1 drive('0, 1'b0);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!out_valid && lat < 10);
      checks++;
      if (lat != 2) begin
         errors++;
         $display("FAIL latency: got %0d cycles, expected 2", lat);
      end
      if (out_valid) begin
         got = {out_y, out_error, out_overflow, out_inexact};
         e = exp_q.pop_front();
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL tie_even: got y=%h e=%b o=%b i=%b, expected y=%h e=%b o=%b i=%b",
                     got.y, got.err, got.ovf, got.inx, e.y, e.err, e.ovf, e.inx);
         end
      end
      @(posedge clk); #1;
      exp_q.delete();
   endtask

   // Stream of rounding and special-case vectors with random downstream stalls.
   task automatic test_rounding();
      vin_t vi[12];
      res_t vo[12];
      int   sent = 0;
      int   got_n = 0;
      int   cyc = 0;
      res_t got;
      res_t e;
      vi[0]  = mk(1'b0, 8'h7F, 23'h000001, 1'b1, 1'b0, 1'b0, 1'b0); vo[0]  = mr(32'h3F800002, 1'b0, 1'b0, 1'b1);
      vi[1]  = mk(1'b0, 8'h7F, 23'h7FFFFF, 1'b1, 1'b1, 1'b0, 1'b0); vo[1]  = mr(32'h40000000, 1'b0, 1'b0, 1'b1);
      vi[2]  = mk(1'b1, 8'hFE, 23'h7FFFFF, 1'b1, 1'b0, 1'b0, 1'b0); vo[2]  = mr(32'hFF800000, 1'b0, 1'b1, 1'b1);
      vi[3]  = mk(1'b0, 8'h7F, 23'h000000, 1'b1, 1'b1, 1'b1, 1'b0); vo[3]  = mr(32'h7FC00000, 1'b1, 1'b0, 1'b0);
      vi[4]  = mk(1'b0, 8'h80, 23'h123456, 1'b0, 1'b0, 1'b0, 1'b0); vo[4]  = mr(32'h40123456, 1'b0, 1'b0, 1'b0);
      vi[5]  = mk(1'b0, 8'h7F, 23'h000005, 1'b0, 1'b1, 1'b0, 1'b0); vo[5]  = mr(32'h3F800005, 1'b0, 1'b0, 1'b1);
      vi[6]  = mk(1'b1, 8'h7F, 23'h000004, 1'b1, 1'b1, 1'b0, 1'b0); vo[6]  = mr(32'hBF800005, 1'b0, 1'b0, 1'b1);
      vi[7]  = mk(1'b0, 8'hFF, 23'h001234, 1'b0, 1'b0, 1'b0, 1'b0); vo[7]  = mr(32'h7F800000, 1'b0, 1'b1, 1'b0);
      vi[8]  = mk(1'b1, 8'h10, 23'h000000, 1'b0, 1'b0, 1'b0, 1'b1); vo[8]  = mr(32'hFF800000, 1'b0, 1'b1, 1'b0);
      vi[9]  = mk(1'b0, 8'h00, 23'h7FFFFF, 1'b1, 1'b1, 1'b0, 1'b0); vo[9]  = mr(32'h00800000, 1'b0, 1'b0, 1'b1);
      vi[10] = mk(1'b0, 8'h7F, 23'h000002, 1'b1, 1'b0, 1'b0, 1'b0); vo[10] = mr(32'h3F800002, 1'b0, 1'b0, 1'b1);
      vi[11] = mk(1'b1, 8'hFE, 23'h7FFFFF, 1'b1, 1'b0, 1'b1, 1'b1); vo[11] = mr(32'h7FC00000, 1'b1, 1'b0, 1'b0);
      while (got_n < 12 && cyc < 300) begin
         @(posedge clk); #1;
         if (sent < 12) drive(vi[sent], 1'b1);
         else           drive('0, 1'b0);
         out_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         if (in_valid && in_ready) begin
            exp_q.push_back(vo[sent]);
            sent++;
         end
         if (out_valid && out_ready) begin
            got = {out_y, out_error, out_overflow, out_inexact};
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL round_extra: got y=%h with no result expected", got.y);
            end else begin
               e = exp_q.pop_front();
               if (got !== e) begin
                  errors++;
                  $display("FAIL round_vec%0d: got y=%h e=%b o=%b i=%b, expected y=%h e=%b o=%b i=%b",
                           got_n, got.y, got.err, got.ovf, got.inx, e.y, e.err, e.ovf, e.inx);
               end
            end
            got_n++;
         end
         cyc++;
      end
      @(posedge clk); #1 drive('0, 1'b0); out_ready = 1'b1;
      checks++;
      if (got_n != 12) begin
         errors++;
         $display("FAIL round_timeout: got %0d results, expected 12", got_n);
      end
   endtask

   task automatic test_trunc();
      vin_t vi[2];
      res_t vo[2];
      int   cyc;
      res_t got;
      vi[0] = mk(1'b0, 8'h7F, 23'h000001, 1'b1, 1'b0, 1'b0, 1'b0); vo[0] = mr(32'h3F800001, 1'b0, 1'b0, 1'b1);
      vi[1] = mk(1'b0, 8'h7F, 23'h7FFFFF, 1'b1, 1'b1, 1'b0, 1'b0); vo[1] = mr(32'h3FFFFFFF, 1'b0, 1'b0, 1'b1);
      t_out_ready = 1'b1;
      for (int k = 0; k < 2; k++) begin
         @(posedge clk); #1 t_drive(vi[k], 1'b1);
         @(posedge clk); #1 t_drive('0, 1'b0);
         cyc = 0;
         while (!t_out_valid && cyc < 10) begin
            @(negedge clk);
            cyc++;
         end
         got = {t_out_y, t_out_error, t_out_overflow, t_out_inexact};
         checks++;
         if (!t_out_valid || got !== vo[k]) begin
            errors++;
            $display("FAIL trunc_vec%0d: got v=%b y=%h i=%b, expected y=%h i=%b",
                     k, t_out_valid, got.y, got.inx, vo[k].y, vo[k].inx);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_flags();
      int   cyc;
      res_t got;
      res_t e;
      // The rounding stream delivered overflow, error and inexact results.
      @(negedge clk);
      checks++;
      if ({flag_overflow, flag_error, flag_inexact} !== 3'b111) begin
         errors++;
         $display("FAIL flags_set: got %b, expected 111", {flag_overflow, flag_error, flag_inexact});
      end
      @(posedge clk); #1 flag_clr = 1'b1;
      @(posedge clk); #1 flag_clr = 1'b0;
      @(negedge clk);
      checks++;
      if ({flag_overflow, flag_error, flag_inexact} !== 3'b000) begin
         errors++;
         $display("FAIL flags_clear: got %b, expected 000", {flag_overflow, flag_error, flag_inexact});
      end
      // Clear coinciding with a delivering overflow result: set wins.
      out_ready = 1'b0;
      @(posedge clk); #1 drive(mk(1'b0, 8'hFF, 23'h0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1);
      @(negedge clk);
      if (in_valid && in_ready) exp_q.push_back(mr(32'h7F800000, 1'b0, 1'b1, 1'b0));
      @(posedge clk); #1 drive('0, 1'b0);
      cyc = 0;
      while (!out_valid && cyc < 10) begin
         @(negedge clk);
         cyc++;
      end
      @(posedge clk); #1 flag_clr = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (!(out_valid && out_ready) || exp_q.size() == 0) begin
         errors++;
         $display("FAIL flags_xfer: got out_valid=%b queued=%0d, expected 1 and 1", out_valid, exp_q.size());
      end else begin
         got = {out_y, out_error, out_overflow, out_inexact};
         e = exp_q.pop_front();
         if (got !== e) begin
            errors++;
            $display("FAIL flags_inf: got y=%h o=%b i=%b, expected y=%h o=%b i=%b",
                     got.y, got.ovf, got.inx, e.y, e.ovf, e.inx);
         end
      end
      @(posedge clk); #1 flag_clr = 1'b0;
      @(negedge clk);
      checks++;
      if ({flag_overflow, flag_error, flag_inexact} !== 3'b100) begin
         errors++;
         $display("FAIL flags_set_wins: got %b, expected 100", {flag_overflow, flag_error, flag_inexact});
      end
      @(posedge clk); #1 flag_clr = 1'b1;
      @(posedge clk); #1 flag_clr = 1'b0;
      @(negedge clk);
      checks++;
      if (flag_overflow !== 1'b0) begin
         errors++;
         $display("FAIL flags_clear2: flag_overflow got %b, expected 0", flag_overflow);
      end
   endtask

   task automatic test_backpressure();
      int          sent = 0;
      int          got_n = 0;
      int          cyc = 0;
      logic [31:0] held;
      res_t        got;
      res_t        e;
      vin_t        v;
      out_ready = 1'b0;
      held = '0;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         v = mk(1'b0, 8'h81, 23'(sent * 32'h111 + 32'h1), 1'b0, 1'b0, 1'b0, 1'b0);
         drive(v, 1'b1);
         @(negedge clk);
         if (in_valid && in_ready) begin
            exp_q.push_back(mr(32'h40800000 | {9'h0, v.frac}, 1'b0, 1'b0, 1'b0));
            sent++;
         end
         if (c == 2) held = out_y;
         if (c > 2) begin
            checks++;
            if (!out_valid || out_y !== held) begin
               errors++;
               $display("FAIL bp_stable: got v=%b y=%h, expected v=1 y=%h", out_valid, out_y, held);
            end
         end
      end
      checks++;
      if (sent != 2 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL bp_accept: got %0d accepted in_ready=%b, expected 2 and 0", sent, in_ready);
      end
      while (got_n < 4 && cyc < 40) begin
         @(posedge clk); #1;
         out_ready = 1'b1;
         if (sent < 4) begin
            v = mk(1'b0, 8'h81, 23'(sent * 32'h111 + 32'h1), 1'b0, 1'b0, 1'b0, 1'b0);
            drive(v, 1'b1);
         end else begin
            v = '0;
            drive(v, 1'b0);
         end
         @(negedge clk);
         if (in_valid && in_ready) begin
            exp_q.push_back(mr(32'h40800000 | {9'h0, v.frac}, 1'b0, 1'b0, 1'b0));
            sent++;
         end
         if (out_valid && out_ready) begin
            got = {out_y, out_error, out_overflow, out_inexact};
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL bp_extra: got y=%h with no result expected", got.y);
            end else begin
               e = exp_q.pop_front();
               if (got !== e) begin
                  errors++;
                  $display("FAIL bp_order%0d: got y=%h, expected y=%h", got_n, got.y, e.y);
               end
            end
            got_n++;
         end
         cyc++;
      end
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1 drive('0, 1'b0);
         @(negedge clk);
         if (out_valid) got_n++;
      end
      checks++;
      if (got_n != 4 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL bp_count: got %0d outputs with %0d pending, expected 4 and 0", got_n, exp_q.size());
      end
   endtask

   task automatic test_reset_midstream();
      int   n = 0;
      int   cyc = 0;
      res_t got;
      res_t e;
      // Deliver an inexact result so a flag is set before reset.
      out_ready = 1'b1;
      @(posedge clk); #1 drive(mk(1'b0, 8'h7F, 23'h0, 1'b0, 1'b1, 1'b0, 1'b0), 1'b1);
      @(posedge clk); #1 drive('0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (flag_inexact !== 1'b1) begin
         errors++;
         $display("FAIL rstm_pre_flag: flag_inexact got %b, expected 1", flag_inexact);
      end
      // Fill both stages.
      out_ready = 1'b0;
      drive(mk(1'b0, 8'h82, 23'h0000AA, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1);
      while (in_ready && cyc < 10) begin
         @(posedge clk); #1;
         cyc++;
      end
      drive('0, 1'b0);
      #1 rst = 1'b1;
      #1;
      checks++;
      if ({out_valid, out_y, flag_overflow, flag_error, flag_inexact} !== 36'h0) begin
         errors++;
         $display("FAIL rstm_async: got v=%b y=%h flags=%b, expected all zero",
                  out_valid, out_y, {flag_overflow, flag_error, flag_inexact});
      end
      exp_q.delete();
      @(posedge clk); #1 rst = 1'b0;
      out_ready = 1'b1;
      drive(mk(1'b1, 8'h83, 23'h000055, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1);
      @(negedge clk);
      if (in_valid && in_ready) exp_q.push_back(mr(32'hC1800055, 1'b0, 1'b0, 1'b0));
      @(posedge clk); #1 drive('0, 1'b0);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (out_valid && out_ready) begin
            got = {out_y, out_error, out_overflow, out_inexact};
            n++;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL rstm_stale: got y=%h with no result expected", got.y);
            end else begin
               e = exp_q.pop_front();
               if (got !== e) begin
                  errors++;
                  $display("FAIL rstm_value: got y=%h, expected y=%h", got.y, e.y);
               end
            end
         end
      end
      checks++;
      if (n != 1) begin
         errors++;
         $display("FAIL rstm_count: got %0d outputs, expected 1", n);
      end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_rounding();
      test_trunc();
      test_flags();
      test_backpressure();
      test_reset_midstream();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_fmul_round_stage
`default_nettype wire
